noise_voice: RTL

Noise voice stage that sits directly downstream of the 8-bit LFSR random source. It consumes the free-running random byte stream, resamples it at a programmable pitch with a phase-accumulator sample-and-hold, and shapes the result with a gated attack/release envelope. It emits one unsigned 8-bit audio sample per sample-rate tick to the mixer.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/noise_voice_if.sv | 32 +++
 rtl/env_ar.sv | 82 ++++++++
 rtl/noise_voice.sv | 79 +++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// synth_pkg : shared envelope types and constants for synth voices
// rev 1.0
// ---------------------------------------------------------------
package synth_pkg;

   localparam int ENV_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   localparam logic [ENV_W_DEFAULT-1:0] ENV_FULL = '1;

endpackage
`default_nettype wire

// File: rtl/noise_voice_if.sv
`default_nettype none
// ---------------------------------------------------------------
// noise_voice_if : control inputs and sample output of a noise voice
// rev 1.0
// ---------------------------------------------------------------
interface noise_voice_if #(
   parameter int ACC_W = 24,
   parameter int ENV_W = 16
) ();

   logic             tick;
   logic [7:0]       rnd_in;
   logic [ACC_W-1:0] freq;
   logic             gate;
   logic [ENV_W-1:0] attack_step;
   logic [ENV_W-1:0] release_step;
   logic [7:0]       sample_out;
   logic             out_valid;
   logic             active;

   modport master (
      output tick, rnd_in, freq, gate, attack_step, release_step,
      input  sample_out, out_valid, active
   );

   modport slave (
      input  tick, rnd_in, freq, gate, attack_step, release_step,
      output sample_out, out_valid, active
   );

endinterface
`default_nettype wire

// File: rtl/env_ar.sv
`default_nettype none
// ---------------------------------------------------------------
// env_ar : gated attack/release envelope with retrigger
// rev 1.0
// ---------------------------------------------------------------
module env_ar
   import synth_pkg::*;
#(
   parameter int ENV_W = ENV_W_DEFAULT
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             tick_i,
   input  wire logic             gate_i,
   input  wire logic [ENV_W-1:0] attack_step_i,
   input  wire logic [ENV_W-1:0] release_step_i,
   output      logic [7:0]       gain_o,
   output      logic             active_o
);

   localparam logic [ENV_W-1:0] C_FULL = {ENV_W{1'b1}};

   env_state_t       state_q, state_d;
   logic [ENV_W-1:0] env_q, env_d;
   logic             gate_q;
   logic             active_q;
   logic [ENV_W:0]   attack_sum;

   assign attack_sum = {1'b0, env_q} + {1'b0, attack_step_i};

   // Gate edges override the per-tick step; env carries over unchanged.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      if (gate_i && !gate_q) begin
         state_d = ATTACK;
      end else if (!gate_i && gate_q && (state_q == ATTACK || state_q == SUSTAIN)) begin
         state_d = RELEASE;
      end else begin
         case (state_q)
            ATTACK: begin
               if (attack_step_i == '0 || attack_sum[ENV_W] ||
                   attack_sum[ENV_W-1:0] == C_FULL) begin
                  env_d   = C_FULL;
                  state_d = SUSTAIN;
               end else begin
                  env_d = attack_sum[ENV_W-1:0];
               end
            end
            SUSTAIN: env_d = C_FULL;
            RELEASE: begin
               if (release_step_i == '0 || env_q <= release_step_i) begin
                  env_d   = '0;
                  state_d = IDLE;
               end else begin
                  env_d = env_q - release_step_i;
               end
            end
            default: env_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         env_q    <= '0;
         gate_q   <= 1'b0;
         active_q <= 1'b0;
      end else if (tick_i) begin
         state_q  <= state_d;
         env_q    <= env_d;
         gate_q   <= gate_i;
         active_q <= (state_d != IDLE);
      end
   end

   assign gain_o   = env_q[ENV_W-1 -: 8];
   assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/noise_voice.sv
`default_nettype none
// ---------------------------------------------------------------
// noise_voice : pitched sample-and-hold noise with AR envelope
// rev 1.0
// ---------------------------------------------------------------
module noise_voice
   import synth_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int ENV_W = ENV_W_DEFAULT
) (
   input wire logic     clk,
   input wire logic     rst,
   noise_voice_if.slave bus
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W:0]   acc_sum;
   logic [7:0]       hold_q, hold_d;
   logic [7:0]       gain;
   logic             active;
   logic [15:0]      prod;
   logic             tick_q;
   logic             out_valid_q;
   logic [7:0]       sample_out_q;

   // Carry out of the accumulator is the resample strobe.
   always_comb begin
      acc_sum = {1'b0, acc_q} + {1'b0, bus.freq};
      acc_d   = acc_sum[ACC_W-1:0];
      hold_d  = acc_sum[ACC_W] ? bus.rnd_in : hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         hold_q <= '0;
      end else if (bus.tick) begin
         acc_q  <= acc_d;
         hold_q <= hold_d;
      end
   end

   env_ar #(
      .ENV_W (ENV_W)
   ) u_env (
      .clk            (clk),
      .rst            (rst),
      .tick_i         (bus.tick),
      .gate_i         (bus.gate),
      .attack_step_i  (bus.attack_step),
      .release_step_i (bus.release_step),
      .gain_o         (gain),
      .active_o       (active)
   );

   assign prod = {8'd0, hold_q} * {8'd0, gain};

   // Output stage runs one cycle behind the tick so it sees post-tick state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         sample_out_q <= '0;
      end else begin
         tick_q      <= bus.tick;
         out_valid_q <= tick_q;
         if (tick_q) begin
            sample_out_q <= prod[15:8];
         end
      end
   end

   assign bus.sample_out = sample_out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.active     = active;

endmodule
`default_nettype wire
